// File: rtl/axi_ar_rr_scheduler.sv
// axi_ar_rr_scheduler: round-robin owner of one AR address generator.
// Optional watchdog on WAIT_LAST: define AXI_AR_SCHED_TIMEOUT_EN.
module axi_ar_rr_scheduler #(
    parameter int  NUM_REQ = 4,
    parameter int  ADDR_W  = 32,
    parameter int  TIMEOUT = 1024,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]      req_len,
    input  logic [NUM_REQ*3-1:0]      req_size,
    input  logic [NUM_REQ*2-1:0]      req_burst,
    input  logic [NUM_REQ*3-1:0]      req_prot,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      ag_valid,
    input  logic                      ag_ready,
    output logic [ADDR_W-1:0]         ag_addr,
    output logic [7:0]                ag_len,
    output logic [2:0]                ag_size,
    output logic [1:0]                ag_burst,
    output logic [2:0]                ag_prot,
    input  logic                      rvalid_in,
    input  logic                      rready_in,
    input  logic                      rlast_in,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
`ifdef AXI_AR_SCHED_TIMEOUT_EN
    ,
    output logic                      err_timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LAST = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic               ag_valid_q, ag_valid_d;
    logic [ADDR_W-1:0]  ag_addr_q, ag_addr_d;
    logic [7:0]         ag_len_q, ag_len_d;
    logic [2:0]         ag_size_q, ag_size_d;
    logic [1:0]         ag_burst_q, ag_burst_d;
    logic [2:0]         ag_prot_q, ag_prot_d;

`ifdef AXI_AR_SCHED_TIMEOUT_EN
    logic [15:0]        cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    logic               any_req;
    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    idx;
    logic               r_last_hs;

    assign r_last_hs = rvalid_in & rready_in & rlast_in;

    // Round-robin pick: first valid queue after the previous owner
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                sel     = idx;
            end
        end
    end

    // Next-state, pop strobe and descriptor capture
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        ag_valid_d = ag_valid_q;
        ag_addr_d  = ag_addr_q;
        ag_len_d   = ag_len_q;
        ag_size_d  = ag_size_q;
        ag_burst_d = ag_burst_q;
        ag_prot_d  = ag_prot_q;
        req_ready  = '0;
`ifdef AXI_AR_SCHED_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req && !reset) begin
                    req_ready[sel] = 1'b1;
                    ag_addr_d  = req_addr[int'(sel)*ADDR_W +: ADDR_W];
                    ag_len_d   = req_len[int'(sel)*8 +: 8];
                    ag_size_d  = req_size[int'(sel)*3 +: 3];
                    ag_burst_d = req_burst[int'(sel)*2 +: 2];
                    ag_prot_d  = req_prot[int'(sel)*3 +: 3];
                    grant_id_d = sel;
                    rr_ptr_d   = sel;
                    ag_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (ag_ready) begin
                    ag_valid_d = 1'b0;
                    state_d    = WAIT_LAST;
`ifdef AXI_AR_SCHED_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            WAIT_LAST: begin
                if (r_last_hs) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`ifdef AXI_AR_SCHED_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: begin
                busy_d     = 1'b0;
                ag_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            ag_valid_q <= 1'b0;
            ag_addr_q  <= '0;
            ag_len_q   <= '0;
            ag_size_q  <= '0;
            ag_burst_q <= '0;
            ag_prot_q  <= '0;
`ifdef AXI_AR_SCHED_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            ag_valid_q <= ag_valid_d;
            ag_addr_q  <= ag_addr_d;
            ag_len_q   <= ag_len_d;
            ag_size_q  <= ag_size_d;
            ag_burst_q <= ag_burst_d;
            ag_prot_q  <= ag_prot_d;
`ifdef AXI_AR_SCHED_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign ag_valid = ag_valid_q;
    assign ag_addr  = ag_addr_q;
    assign ag_len   = ag_len_q;
    assign ag_size  = ag_size_q;
    assign ag_burst = ag_burst_q;
    assign ag_prot  = ag_prot_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
`ifdef AXI_AR_SCHED_TIMEOUT_EN
    assign err_timeout = err_q;
`endif

endmodule
